// File: rtl/imm_encoder_if.sv
// Valid/ready bus for imm_encoder: immediate/template in, encoded word out.
// master drives the inputs and accepts the results; slave is the encoder.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_imm;
  logic [31:0] in_tmpl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;

  modport master (
    output in_valid, in_op, in_imm, in_tmpl, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  modport slave (
    input  in_valid, in_op, in_imm, in_tmpl, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Scatters a 32-bit immediate into an RV32I template word, 2-stage pipeline.
// Define IMM_RANGE_CHECK_EN to flag immediates the format cannot represent.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_encoder_if.slave     bus,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic             s1_valid_q;
  logic [2:0]       s1_op_q;
  logic [31:0]      s1_imm_q;
  logic [31:0]      s1_tmpl_q;
  logic             s2_valid_q;
  logic [31:0]      inst_q;
  logic             err_q;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic        adv2, adv1, in_hs, out_hs;
  logic        is_i, is_s, is_b, is_u, is_j;
  logic [31:0] enc_inst;
  logic        enc_err;

  assign adv2   = !s2_valid_q || bus.out_ready;
  assign adv1   = !s1_valid_q || adv2;
  assign in_hs  = bus.in_valid && bus.in_ready;
  assign out_hs = s2_valid_q && bus.out_ready;

  assign bus.in_ready  = rst_n && adv1;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_inst  = inst_q;
  assign bus.out_err   = err_q;
  assign enc_cnt       = enc_cnt_q;
  assign err_cnt       = err_cnt_q;

  assign is_i = (s1_op_q == 3'b000);
  assign is_s = (s1_op_q == 3'b010);
  assign is_b = (s1_op_q == 3'b110);
  assign is_u = (s1_op_q == 3'b011);
  assign is_j = (s1_op_q == 3'b111);

`ifdef IMM_RANGE_CHECK_EN
  logic fits_12, fits_b, fits_j, fits_u, fits;

  // A value fits n bits signed when all bits above n-1 equal the sign.
  assign fits_12 = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
  assign fits_b  = ((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12]))
                && !s1_imm_q[0];
  assign fits_j  = ((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]))
                && !s1_imm_q[0];
  assign fits_u  = !(|s1_imm_q[11:0]);

  always_comb begin
    fits = 1'b1;
    unique case (1'b1)
      is_i, is_s: fits = fits_12;
      is_b:       fits = fits_b;
      is_j:       fits = fits_j;
      is_u:       fits = fits_u;
      default:    fits = 1'b1;
    endcase
  end
`endif

  always_comb begin
    enc_inst = s1_tmpl_q;
    enc_err  = 1'b0;
    unique case (1'b1)
      is_i: enc_inst = {s1_imm_q[11:0], s1_tmpl_q[19:0]};
      is_s: enc_inst = {s1_imm_q[11:5], s1_tmpl_q[24:12],
                        s1_imm_q[4:0], s1_tmpl_q[6:0]};
      is_b: enc_inst = {s1_imm_q[12], s1_imm_q[10:5],
                        s1_tmpl_q[24:12], s1_imm_q[4:1],
                        s1_imm_q[11], s1_tmpl_q[6:0]};
      is_u: enc_inst = {s1_imm_q[31:12], s1_tmpl_q[11:0]};
      is_j: enc_inst = {s1_imm_q[20], s1_imm_q[10:1],
                        s1_imm_q[11], s1_imm_q[19:12],
                        s1_tmpl_q[11:0]};
      default: enc_err = 1'b1;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    if (!enc_err && !fits) begin
      enc_inst = s1_tmpl_q;
      enc_err  = 1'b1;
    end
`endif
  end

  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (out_hs && !(&enc_cnt_q))
      enc_cnt_d = enc_cnt_q + CNT_W'(1);
    if (out_hs && err_q && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      inst_q     <= 32'h0;
      err_q      <= 1'b0;
      enc_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
      if (adv1)
        s1_valid_q <= bus.in_valid;
      if (adv2)
        s2_valid_q <= s1_valid_q;
      // Output data only moves with a real beat, so it holds while stalled.
      if (adv2 && s1_valid_q) begin
        inst_q <= enc_inst;
        err_q  <= enc_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs) begin
      s1_op_q   <= bus.in_op;
      s1_imm_q  <= bus.in_imm;
      s1_tmpl_q <= bus.in_tmpl;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: scoreboard model plus directed pins.
// Expectations follow IMM_RANGE_CHECK_EN the same way the design does.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] enc_cnt, err_cnt;

  always #5 clk = ~clk;

  imm_encoder_if bus();

  imm_encoder #(.CNT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .enc_cnt (enc_cnt),
    .err_cnt (err_cnt)
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        q[$];
  exp_t        mon_e;
  int          m_enc = 0;
  int          m_err = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_inst;
  logic        prev_err;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  // Which immediate bit lands on instruction bit b, or -1 for template.
  function automatic int src_bit(int fmt, int b);
    case (fmt)
      0: return (b >= 20) ? b - 20 : -1;
      1: begin
        if (b >= 25) return b - 20;
        if (b >= 7 && b <= 11) return b - 7;
        return -1;
      end
      2: begin
        if (b == 31) return 12;
        if (b >= 25) return b - 20;
        if (b >= 8 && b <= 11) return b - 7;
        if (b == 7) return 11;
        return -1;
      end
      3: return (b >= 12) ? b : -1;
      4: begin
        if (b == 31) return 20;
        if (b >= 21) return b - 20;
        if (b == 20) return 11;
        if (b >= 12) return b;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  function automatic exp_t model(logic [2:0] op, logic [31:0] imm,
                                 logic [31:0] tmpl);
    exp_t   r;
    int     fmt;
    int     s;
    longint v;
    bit     ok;
    r.inst = tmpl;
    r.err  = 1'b0;
    case (op)
      3'b000:  fmt = 0;
      3'b010:  fmt = 1;
      3'b110:  fmt = 2;
      3'b011:  fmt = 3;
      3'b111:  fmt = 4;
      default: fmt = -1;
    endcase
    if (fmt < 0) begin
      r.err = 1'b1;
      return r;
    end
    v  = longint'($signed(imm));
    ok = 1'b1;
    case (fmt)
      0, 1: ok = (v >= -2048 && v <= 2047);
      2:    ok = (v >= -4096 && v <= 4094 && (v % 2) == 0);
      4:    ok = (v >= -1048576 && v <= 1048574 && (v % 2) == 0);
      default: ok = ((imm & 32'hFFF) == 32'h0);
    endcase
    if (RC && !ok) begin
      r.err = 1'b1;
      return r;
    end
    for (int b = 0; b < 32; b++) begin
      s = src_bit(fmt, b);
      if (s >= 0) r.inst[b] = imm[s];
    end
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected progress", name);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_enc = 0;
      m_err = 0;
      prev_stall = 0;
    end else begin
      chk("enc_cnt", 32'(enc_cnt), 32'(m_enc));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_inst", bus.out_inst, prev_inst);
        chk("hold_err", 32'(bus.out_err), 32'(prev_err));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_out: got beat %h expected none",
                   bus.out_inst);
        end else begin
          mon_e = q.pop_front();
          chk("sb_inst", bus.out_inst, mon_e.inst);
          chk("sb_err", 32'(bus.out_err), 32'(mon_e.err));
          if (m_enc != 65535) m_enc++;
          if (mon_e.err && m_err != 65535) m_err++;
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.in_op, bus.in_imm, bus.in_tmpl));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_inst  = bus.out_inst;
      prev_err   = bus.out_err;
    end
  end

  task automatic run_one(string name, logic [2:0] op, logic [31:0] imm,
                         logic [31:0] tmpl, logic [31:0] ei, logic ee);
    int t;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_imm   = imm;
    bus.in_tmpl  = tmpl;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) fail_now({name, "_accept"});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({name, "_lat2"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_inst"}, bus.out_inst, ei);
    chk({name, "_err"}, 32'(bus.out_err), 32'(ee));
  endtask

  function automatic logic [31:0] rand_imm();
    int unsigned k;
    logic [31:0] edges [12];
    edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049,
              32'd4094, 32'd4095, -32'sd4096, -32'sd4098,
              32'd1048574, 32'd1048576, -32'sd1048576, 32'h12345000};
    k = $urandom_range(0, 3);
    if (k == 0) return $urandom;
    if (k == 1) return edges[$urandom_range(0, 11)];
    return 32'($urandom_range(0, 8191)) - 32'd4096;
  endfunction

  function automatic logic [2:0] rand_op();
    logic [2:0] ops [10];
    ops = '{3'b000, 3'b000, 3'b010, 3'b010, 3'b110,
            3'b110, 3'b011, 3'b111, 3'b111, 3'b001};
    if ($urandom_range(0, 19) == 0) return 3'($urandom_range(4, 5));
    return ops[$urandom_range(0, 9)];
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t p;
    int   sent;
    int   cyc;

    bus.in_valid  = 1'b0;
    bus.in_op     = 3'b000;
    bus.in_imm    = 32'h0;
    bus.in_tmpl   = 32'h0;
    bus.out_ready = 1'b0;

    p = model(3'b000, 32'hFFFF_FFFF, 32'h13);
    chk("pin_I", p.inst, 32'hFFF00013);
    p = model(3'b010, 32'd8, 32'h2023);
    chk("pin_S", p.inst, 32'h00002423);
    p = model(3'b110, -32'sd4, 32'h63);
    chk("pin_B", p.inst, 32'hFE000EE3);
    p = model(3'b111, 32'd8, 32'h6F);
    chk("pin_J", p.inst, 32'h0080006F);
    p = model(3'b011, 32'h12345000, 32'h37);
    chk("pin_U", p.inst, 32'h12345037);
    p = model(3'b000, 32'd2048, 32'h13);
    chk("pin_I2048", p.inst, RC ? 32'h13 : 32'h80000013);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_inst", bus.out_inst, 32'h0);
    chk("rst_err", 32'(bus.out_err), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_enc", 32'(enc_cnt), 32'd0);
    chk("rst_errc", 32'(err_cnt), 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    run_one("t1_I", 3'b000, 32'hFFFF_FFFF, 32'h13, 32'hFFF00013, 1'b0);
    run_one("t2_S", 3'b010, 32'd8, 32'h2023, 32'h00002423, 1'b0);
    run_one("t2_B", 3'b110, -32'sd4, 32'h63, 32'hFE000EE3, 1'b0);
    run_one("t3_J", 3'b111, 32'd8, 32'h6F, 32'h0080006F, 1'b0);
    run_one("t3_U", 3'b011, 32'h12345000, 32'h37, 32'h12345037, 1'b0);
    run_one("t4_I2048", 3'b000, 32'd2048, 32'h13,
            RC ? 32'h13 : 32'h80000013, RC);
    run_one("t6_ill", 3'b001, 32'd5, 32'hABCD1234, 32'hABCD1234, 1'b1);
    repeat (2) @(negedge clk);
    chk("dir_enc_cnt", 32'(enc_cnt), 32'd7);
    chk("dir_err_cnt", 32'(err_cnt), RC ? 32'd2 : 32'd1);

    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op     = 3'b000;
    bus.in_imm    = 32'd1;
    @(posedge clk); #1;
    bus.in_imm    = 32'd2;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    chk("mid_full", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mid_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_enc", 32'(enc_cnt), 32'd0);
    chk("mid_errc", 32'(err_cnt), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_quiet", 32'(bus.out_valid), 32'd0);
    end

    sent = 0;
    cyc  = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_op    = rand_op();
    bus.in_imm   = rand_imm();
    bus.in_tmpl  = $urandom;
    while (sent < 1000 && cyc < 20000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.in_ready) begin
        sent++;
        @(posedge clk); #1;
        bus.in_op   = rand_op();
        bus.in_imm  = rand_imm();
        bus.in_tmpl = $urandom;
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (sent < 1000) fail_now("rand_send");

    cyc = 0;
    @(negedge clk);
    while ((q.size() != 0 || bus.out_valid) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) fail_now("rand_drain");
    chk("rand_enc_cnt", 32'(enc_cnt), 32'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
